// File: rtl/ste_bar_level_gen.sv
// Averages raw ADC samples over a power-of-two window and scales each average to a bar level,
// with optional peak-hold and stepwise decay, driving the LED bar stage directly.
module ste_bar_level_gen #(
  parameter int ADC_W    = 12,
  parameter int DATA_W   = 3,
  parameter int DATA_MAX = 7,
  parameter int AVG_LOG2 = 4,
  parameter int HOLD_UPD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  sample_i,
  input  logic              sample_valid_i,
  input  logic              hold_en_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] level_o,
  output logic              level_update_o,
  output logic [DATA_W-1:0] peak_o,
  output logic              bar_clr_o
);

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int PROD_W = ADC_W + DATA_W + 1;
  localparam int HC_W   = (HOLD_UPD > 1) ? $clog2(HOLD_UPD) : 1;

  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
  localparam logic [HC_W-1:0]     HC_LAST  = HC_W'(HOLD_UPD - 1);
  localparam logic [DATA_W:0]     SCALE    = (DATA_W + 1)'(DATA_MAX + 1);
  localparam logic [DATA_W:0]     LVL_MAX  = (DATA_W + 1)'(DATA_MAX);
  localparam logic [DATA_W-1:0]   LVL_SAT  = DATA_W'(DATA_MAX);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] cnt;
  logic                s1_valid;
  logic [ADC_W-1:0]    avg_q;
  logic                win_done;

  logic [PROD_W-1:0]   prod;
  logic [DATA_W:0]     prod_hi;
  logic [DATA_W-1:0]   lvl;

  logic [DATA_W-1:0]   peak;
  logic [DATA_W-1:0]   peak_dec;
  logic [DATA_W-1:0]   peak_nxt;
  logic [HC_W-1:0]     hold_cnt;
  logic [HC_W-1:0]     hold_nxt;

  assign acc_sum  = acc + ACC_W'(sample_i);
  assign win_done = sample_valid_i && (cnt == CNT_LAST);

  // Stage 1: window accumulation; the final sample folds straight into the average.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      avg_q    <= '0;
    end else if (clr_i) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      avg_q    <= '0;
    end else begin
      s1_valid <= 1'b0;
      if (win_done) begin
        avg_q    <= ADC_W'(acc_sum >> AVG_LOG2);
        acc      <= '0;
        cnt      <= '0;
        s1_valid <= 1'b1;
      end else if (sample_valid_i) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Full-width product so the scale never truncates before the shift.
  assign prod    = PROD_W'(avg_q) * PROD_W'(SCALE);
  assign prod_hi = prod[PROD_W-1:ADC_W];
  assign lvl     = (prod_hi > LVL_MAX) ? LVL_SAT : prod_hi[DATA_W-1:0];

  // A lower level only reaches the peak after HOLD_UPD updates, then decays one step at a time.
  assign peak_dec = peak - 1'b1;

  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold_cnt;
    if (lvl >= peak) begin
      peak_nxt = lvl;
      hold_nxt = '0;
    end else if (hold_cnt == HC_LAST) begin
      peak_nxt = (peak_dec > lvl) ? peak_dec : lvl;
      hold_nxt = '0;
    end else begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  // Stage 2: scaling, peak tracking and the bar-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak           <= '0;
      hold_cnt       <= '0;
      level_o        <= '0;
      level_update_o <= 1'b0;
    end else if (clr_i) begin
      peak           <= '0;
      hold_cnt       <= '0;
      level_o        <= '0;
      level_update_o <= 1'b0;
    end else begin
      level_update_o <= s1_valid;
      if (s1_valid) begin
        peak     <= peak_nxt;
        hold_cnt <= hold_nxt;
        level_o  <= hold_en_i ? peak_nxt : lvl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_clr_o <= 1'b0;
    end else begin
      bar_clr_o <= clr_i;
    end
  end

  assign peak_o = peak;

endmodule

// File: tb/tb_ste_bar_level_gen.sv
// Scoreboard bench for ste_bar_level_gen: a window/peak reference model queues expected
// strobes, and a negedge monitor pops and compares whenever the DUT strobes.
module tb_ste_bar_level_gen;
  localparam int ADC_W    = 12;
  localparam int DATA_W   = 3;
  localparam int DATA_MAX = 7;
  localparam int AVG_LOG2 = 4;
  localparam int HOLD_UPD = 8;
  localparam int WIN      = 1 << AVG_LOG2;
  localparam int FULL     = (1 << ADC_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADC_W-1:0]  sample_i = '0;
  logic              sample_valid_i = 1'b0;
  logic              hold_en_i = 1'b0;
  logic              clr_i = 1'b0;
  logic [DATA_W-1:0] level_o;
  logic              level_update_o;
  logic [DATA_W-1:0] peak_o;
  logic              bar_clr_o;

  ste_bar_level_gen #(
    .ADC_W(ADC_W), .DATA_W(DATA_W), .DATA_MAX(DATA_MAX),
    .AVG_LOG2(AVG_LOG2), .HOLD_UPD(HOLD_UPD)
  ) dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .hold_en_i(hold_en_i), .clr_i(clr_i), .level_o(level_o),
    .level_update_o(level_update_o), .peak_o(peak_o), .bar_clr_o(bar_clr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int lvl;
    int peak;
  } exp_t;

  exp_t q[$];
  bit   hold_hist[int];
  bit   clr_hist[int];

  int errors = 0;
  int checks = 0;

  // Reference model state: the samples of the open window and the displayed/peak values.
  int m_sum = 0, m_n = 0, m_peak = 0, m_hold = 0;
  int cur_disp = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_sum = 0; m_n = 0; m_peak = 0; m_hold = 0; cur_disp = 0;
  endfunction

  task automatic step(bit r, bit v, int s, bit c, bit h);
    int avg, l;
    rst = r; sample_valid_i = v; sample_i = ADC_W'(s); clr_i = c; hold_en_i = h;
    @(posedge clk);
    #1;
    hold_hist[cyc] = h;
    clr_hist[cyc]  = c && !r;
    if (r) begin
      model_reset();
      q.delete();
    end else if (c) begin
      model_reset();
      while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
    end else if (v) begin
      m_sum += s;
      m_n++;
      if (m_n == WIN) begin
        avg = m_sum / WIN;
        l = (avg * (DATA_MAX + 1)) / (FULL + 1);
        if (l > DATA_MAX) l = DATA_MAX;
        if (l >= m_peak) begin
          m_peak = l; m_hold = 0;
        end else if (m_hold == HOLD_UPD - 1) begin
          m_peak = (m_peak - 1 > l) ? m_peak - 1 : l;
          m_hold = 0;
        end else begin
          m_hold++;
        end
        q.push_back('{due: cyc + 1, lvl: l, peak: m_peak});
        m_sum = 0; m_n = 0;
      end
    end
  endtask

  task automatic idle(int n, bit h);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, h);
  endtask

  task automatic window(int s, bit h, bit gaps);
    for (int i = 0; i < WIN; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3), h);
      step(0, 1, s, 0, h);
    end
  endtask

  // Monitor: strobe-driven pop-and-compare, plus held-level and bar_clr checks each cycle.
  always @(negedge clk) begin
    exp_t e;
    int exp_l;
    if (cyc > 0 && clr_hist.exists(cyc)) begin
      if (level_update_o) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          exp_l = hold_hist[cyc] ? e.peak : e.lvl;
          check("strobe_cycle", cyc, e.due);
          check("strobe_level", int'(level_o), exp_l);
          check("strobe_peak", int'(peak_o), e.peak);
          cur_disp = exp_l;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          check("missing_strobe", 0, 1);
          void'(q.pop_front());
        end
        check("level_held", int'(level_o), cur_disp);
      end
      check("bar_clr", int'(bar_clr_o), int'(clr_hist[cyc]));
    end
  end

  initial begin
    int v;
    bit h;

    // 1. reset with random inputs
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom_range(0, 1)), $urandom_range(0, FULL), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("rst_level", int'(level_o), 0);
    check("rst_update", int'(level_update_o), 0);
    check("rst_peak", int'(peak_o), 0);
    check("rst_bar_clr", int'(bar_clr_o), 0);
    for (int i = 0; i < WIN - 1; i++) step(0, 1, 2048, 0, 0);
    idle(3, 0);
    check("partial_no_strobe", q.size(), 0);
    step(1, 0, 0, 0, 0);

    // 2. basic averages
    window(2048, 0, 0); idle(2, 0);
    check("avg_2048", int'(level_o), 4);
    window(FULL, 0, 0); idle(2, 0);
    check("avg_full", int'(level_o), DATA_MAX);
    window(0, 0, 1); idle(2, 0);
    check("avg_zero_gaps", int'(level_o), 0);

    // 3. mixed window, immediately followed by another window
    for (int i = 0; i < WIN; i++) step(0, 1, (i < WIN / 2) ? FULL : 0, 0, 0);
    window(2048, 0, 0);
    idle(2, 0);
    check("mixed_then_next", int'(level_o), 4);

    // 4. peak hold and decay
    window(FULL, 1, 0); idle(2, 1);
    check("hold_start", int'(level_o), 7);
    for (int u = 1; u <= 16; u++) begin
      window(0, 1, 0); idle(2, 1);
      check("hold_level", int'(level_o), (u < 8) ? 7 : (u < 16) ? 6 : 5);
      check("hold_peak", int'(peak_o), (u < 8) ? 7 : (u < 16) ? 6 : 5);
    end
    idle(3, 0);
    check("hold_off_keeps", int'(level_o), 5);
    window(0, 0, 0); idle(2, 0);
    check("hold_off_level", int'(level_o), 0);

    // 5. clear with a sample, then a fresh window
    for (int i = 0; i < 10; i++) step(0, 1, FULL, 0, 0);
    step(0, 1, FULL, 1, 0);
    check("clr_bar", int'(bar_clr_o), 1);
    check("clr_level", int'(level_o), 0);
    check("clr_peak", int'(peak_o), 0);
    idle(WIN, 0);
    window(1024, 0, 0); idle(2, 0);
    check("after_clr", int'(level_o), 2);

    // 6. clear while the pipeline holds a finished window
    window(FULL, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(3, 0);
    check("clr_pipe_level", int'(level_o), 0);
    check("clr_pipe_peak", int'(peak_o), 0);

    // Random traffic
    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) h = ~h;
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = FULL;
        default: v = $urandom_range(0, FULL);
      endcase
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), v,
           ($urandom_range(0, 149) == 0), h);
    end
    idle(4, h);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
